// File: rtl/alu_seq_executor.sv
// Multi-cycle ALU: one op per start/ready handshake, registered result plus one-cycle done_o pulse.
// Latency: done in cycle 1 for non-shift ops and shift-by-0, cycle n+1 for shift by n; define ALU_BARREL_SHIFT_EN for one-step shifts.
// Backpressure: ready_o is high only in IDLE; start_i is ignored outside IDLE and nothing is re-sampled.
module alu_seq_executor #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o,
  output logic                  illegal_op_o
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic                  load_res;
  logic [DATA_WIDTH-1:0] res_nxt;
  logic                  ill_nxt;
  logic [DATA_WIDTH-1:0] calc_res;
  logic                  calc_legal;
  logic                  is_shift;

`ifndef ALU_BARREL_SHIFT_EN
  logic [DATA_WIDTH-1:0] work, work_nxt, work_step;
  logic [4:0]            count, count_nxt;
  logic                  shl, shl_nxt;
`endif

  assign is_shift = (ALU_Operation_i == OP_SRL) || (ALU_Operation_i == OP_SLL);

  // Single-step evaluation at accept; iterative shifts only reach here with amount 0.
  always_comb begin
    calc_res   = '0;
    calc_legal = 1'b1;
    case (ALU_Operation_i)
      OP_ADD: calc_res = A_i + B_i;
      OP_SUB: calc_res = A_i - B_i;
      OP_AND: calc_res = A_i & B_i;
      OP_OR:  calc_res = A_i | B_i;
      OP_LUI: calc_res = B_i << 12;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SRL: calc_res = A_i >> B_i[4:0];
      OP_SLL: calc_res = A_i << B_i[4:0];
`else
      OP_SRL: calc_res = A_i;
      OP_SLL: calc_res = A_i;
`endif
      default: begin
        calc_res   = '0;
        calc_legal = 1'b0;
      end
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  assign work_step = shl ? (work << 1) : (work >> 1);
`endif

  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    res_nxt   = calc_res;
    ill_nxt   = ~calc_legal;
`ifndef ALU_BARREL_SHIFT_EN
    work_nxt  = work;
    count_nxt = count;
    shl_nxt   = shl;
`endif
    case (state)
      IDLE: begin
        if (start_i) begin
`ifndef ALU_BARREL_SHIFT_EN
          if (is_shift && (B_i[4:0] != 5'd0)) begin
            state_nxt = SHIFT;
            work_nxt  = A_i;
            count_nxt = B_i[4:0];
            shl_nxt   = (ALU_Operation_i == OP_SLL);
          end else begin
            state_nxt = DONE;
            load_res  = 1'b1;
          end
`else
          state_nxt = DONE;
          load_res  = 1'b1;
`endif
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      SHIFT: begin
        work_nxt  = work_step;
        count_nxt = count - 5'd1;
        // count==1 means this step produces the final shifted value
        if (count == 5'd1) begin
          res_nxt   = work_step;
          ill_nxt   = 1'b0;
          load_res  = 1'b1;
          state_nxt = DONE;
        end
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALU_Result_o <= '0;
      Zero_o       <= 1'b1;
      illegal_op_o <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      work         <= '0;
      count        <= 5'd0;
      shl          <= 1'b0;
`endif
    end else begin
      if (load_res) begin
        ALU_Result_o <= res_nxt;
        Zero_o       <= (res_nxt == '0);
        illegal_op_o <= ill_nxt;
      end
`ifndef ALU_BARREL_SHIFT_EN
      work  <= work_nxt;
      count <= count_nxt;
      shl   <= shl_nxt;
`endif
    end
  end

  assign ready_o = (state == IDLE);
  assign done_o  = (state == DONE);

endmodule

// File: tb/tb_alu_seq_executor.sv
// Scoreboard bench for alu_seq_executor: stimulus pushes expected results, a negedge monitor pops on done_o.
module tb_alu_seq_executor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  ALU_Operation_i = 4'b0000;
  logic [31:0] A_i = '0;
  logic [31:0] B_i = '0;
  logic        ready_o, done_o, Zero_o, illegal_op_o;
  logic [31:0] ALU_Result_o;

  alu_seq_executor #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .ALU_Operation_i(ALU_Operation_i),
    .A_i(A_i), .B_i(B_i), .ready_o(ready_o), .done_o(done_o),
    .ALU_Result_o(ALU_Result_o), .Zero_o(Zero_o), .illegal_op_o(illegal_op_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        i;
    int          dc;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

`ifdef ALU_BARREL_SHIFT_EN
  localparam int LAT_SRL31 = 1;
  localparam int LAT_SH4   = 1;
`else
  localparam int LAT_SRL31 = 32;
  localparam int LAT_SH4   = 5;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", nm, $time);
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        chk("ready_after_done", {31'b0, ready_o}, 32'd1);
        chk("done_one_cycle", {31'b0, done_o}, 32'd0);
      end
      if (done_o) begin
        if (q.size() == 0) begin
          fail_now("spurious_done");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", ALU_Result_o, e.r);
          chk("zero", {31'b0, Zero_o}, {31'b0, e.z});
          chk("illegal", {31'b0, illegal_op_o}, {31'b0, e.i});
          chk("done_cycle", cyc, e.dc);
          chk("ready_low_in_done", {31'b0, ready_o}, 32'd0);
        end
      end
      prev_done = done_o;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic ei,
                       input int lat, input logic hold);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready_o) begin
      fail_now("ready_wait");
      return;
    end
    start_i = 1'b1;
    ALU_Operation_i = op;
    A_i = a;
    B_i = b;
    @(posedge clk);
    #1;
    e.r = er; e.z = ez; e.i = ei; e.dc = cyc + lat - 1;
    q.push_back(e);
    @(negedge clk);
    // Scramble inputs after accept; the op in flight must not see them.
    start_i = hold;
    ALU_Operation_i = 4'b1111;
    A_i = ~a;
    B_i = ~b;
    if (hold) begin
      t = 0;
      while (!done_o && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!done_o) fail_now("hold_done_wait");
      start_i = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) fail_now("drain");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_result", ALU_Result_o, 32'h0);
    chk("rst_zero", {31'b0, Zero_o}, 32'd1);
    chk("rst_illegal", {31'b0, illegal_op_o}, 32'd0);
    reset = 1'b1;

    issue(4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1, 1'b0);
    issue(4'b0001, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 1'b0);
    drain();

    // Reset in cycle 5 of an SLL by 20: discarded with no done pulse.
    start_i = 1'b1; ALU_Operation_i = 4'b0111; A_i = 32'h1; B_i = 32'd20;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, ready_o}, 32'd1);
    chk("midrst_done", {31'b0, done_o}, 32'd0);
    chk("midrst_result", ALU_Result_o, 32'h0);
    chk("midrst_zero", {31'b0, Zero_o}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_ready", {31'b0, ready_o}, 32'd1);

    issue(4'b0110, 32'h8000_0000, 32'd31, 32'h1, 1'b0, 1'b0, LAT_SRL31, 1'b1);
    issue(4'b0111, 32'h1234, 32'd0, 32'h1234, 1'b0, 1'b0, 1, 1'b0);
    issue(4'b0101, 32'h55, 32'h000A_BCDE, 32'hABCD_E000, 1'b0, 1'b0, 1, 1'b0);
    issue(4'b0011, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1, 1'b0);
    issue(4'b0010, 32'hF0, 32'h0F, 32'h0, 1'b1, 1'b0, 1, 1'b0);
    issue(4'b1111, 32'h3, 32'h4, 32'h0, 1'b1, 1'b1, 1, 1'b0);
    issue(4'b0000, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0, 1, 1'b0);
    issue(4'b0111, 32'h1, 32'd4, 32'h10, 1'b0, 1'b0, LAT_SH4, 1'b0);
    issue(4'b0110, 32'hF000_0000, 32'h24, 32'h0F00_0000, 1'b0, 1'b0, LAT_SH4, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
